line_render_scheduler: RTL and testbench
========================================

Name: line_render_scheduler

Overview:
- Sequences the scanline renderer against the VGA output's double-buffered line buffer.
- Line buffer has two halves: half 0 at index 0, half 1 at index LINE_STRIDE.
- Primes line 0 before the playfield, then prefetches source line N+1 into the back half while half N is shown.
- Each source line is shown for 2 scan lines (vga_scale=0) or 4 (vga_scale=1). Late renders are flagged as underruns.
- Sits in the vga_clk domain, between the timing generator and the renderer.

Parameters:
- SRC_LINES, 240, source lines per frame; legal range 2..1023.
- LINE_STRIDE, 640, base index of buffer half 1.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- prime_start  in  1  one-cycle pulse ≥1 line before the first playfield line.
- pf_start  in  1  one-cycle pulse at the start of the first playfield scan line.
- line_end  in  1  one-cycle pulse on the last pixel of every scan line.
- vga_scale  in  1  0: repeat 2; 1: repeat 4. Sampled only on pf_start.
- render_done  in  1  one-cycle pulse: renderer finished the requested line.
- render_req  out  1  level; a render is outstanding.
- render_line  out  10  source line to render.
- render_buffer  out  1  buffer half to write.
- render_base  out  11  render_buffer ? LINE_STRIDE : 0.
- render_abort  out  1  one-cycle pulse; outstanding request withdrawn.
- display_buffer  out  1  half currently being displayed.
- display_base  out  11  display_buffer ? LINE_STRIDE : 0.
- active  out  1  high while the playfield is being displayed.
- underrun  out  1  one-cycle pulse on a swap taken with a render still pending.
- underrun_count  out  8  saturating underrun count; cleared only by reset.

Behaviour:
- Reset: state=IDLE; all outputs 0; rep_cnt=0; src_line=0; latched repeat=2.
- All outputs are registered. render_base and display_base are registered alongside their select bits.
- States: IDLE, PRIME, ARMED, ACTIVE.
- IDLE + prime_start: next cycle render_req=1, render_line=0, render_buffer=0 → PRIME.
- PRIME + render_done: render_req=0 → ARMED.
- PRIME + pf_start: → ACTIVE with the request still held; the first swap checks it.
- ARMED + pf_start: → ACTIVE.
- Entering ACTIVE:
  - active=1; display_buffer=0; rep_cnt=0; src_line=0.
  - Latch repeat = vga_scale ? 4 : 2.
  - Issue the prefetch: render_line=1, render_buffer=1, render_req=1.
- Request rule: render_line and render_buffer are stable while render_req=1.
- Completion rule: render_done is honoured only while render_req=1; otherwise it is ignored. The earliest valid render_done is the cycle after render_req rises.
- ACTIVE, on line_end with rep_cnt < repeat-1: rep_cnt++.
- ACTIVE, on line_end with rep_cnt == repeat-1 (swap):
  - rep_cnt=0; display_buffer toggles; src_line++.
  - If render_req is still 1 and render_done is not asserted the same cycle: pulse underrun, increment underrun_count (hold at 255), and drop render_req.
  - render_done coincident with the swap counts as on time.
  - If the new src_line+1 < SRC_LINES: issue the next request next cycle, with render_line = src_line+1 and render_buffer = the new back half.
  - If src_line reaches SRC_LINES: active=0 → IDLE, no request.
- Last line: no prefetch is issued while src_line = SRC_LINES-1.
- frame_start in any state forces the following, with priority over every other input in the same cycle:
  - state → IDLE; active=0; counters cleared; display_buffer=0.
  - If render_req=1: drop it and pulse render_abort.
- pf_start outside PRIME or ARMED: ignored.
- prime_start outside IDLE: ignored.
- Simultaneous line_end and render_done on a non-swap line: rep_cnt++ and the request completes.
- vga_scale changes mid-frame take effect at the next pf_start.
- src_line arithmetic: 10-bit, with no wrap in legal configurations.

Test Plan:
- Normal, scale 0, SRC_LINES=4, done 10 cycles after each req:
  - Expected: render_line sequence 0,1,2,3 with buffers 0,1,0,1.
  - display_buffer toggles every 2 line_end; active falls after the 8th line_end; underrun_count=0.
- Scale 1: display_buffer toggles every 4 line_end, and the prefetch is issued once per 4 lines.
- Late render:
  - Stimulus: withhold render_done for line 2 past the swap.
  - Expected: underrun pulses once; count=1; render_req drops at the swap; the line-3 request follows next cycle.
- Coincident: render_done in the same cycle as the swap line_end → no underrun, normal prefetch.
- Abort:
  - Stimulus: frame_start while render_req=1 in ACTIVE.
  - Expected next cycle: render_req=0, render_abort=1 for exactly 1 cycle, state IDLE, display_base=0.
- Reset mid-frame: assert reset for 1 cycle in ACTIVE → all outputs 0, underrun_count cleared, prime_start required again.

Source files
------------

// File: rtl/line_render_scheduler_if.sv
// Render request channel between the line render scheduler and the scanline renderer.
//   render_req     level, a render is outstanding (line/buffer/base stable while high)
//   render_line    source line to render
//   render_buffer  line buffer half to write
//   render_base    buffer index of that half
//   render_abort   one-cycle pulse, outstanding request withdrawn
//   render_done    one-cycle pulse from the renderer, honoured only while render_req is high
interface line_render_scheduler_if;
    logic        render_req;
    logic [9:0]  render_line;
    logic        render_buffer;
    logic [10:0] render_base;
    logic        render_abort;
    logic        render_done;

    modport master (
        output render_req,
        output render_line,
        output render_buffer,
        output render_base,
        output render_abort,
        input  render_done
    );

    modport slave (
        input  render_req,
        input  render_line,
        input  render_buffer,
        input  render_base,
        input  render_abort,
        output render_done
    );
endinterface

// File: rtl/line_render_scheduler.sv
// Sequences the scanline renderer against the double-buffered VGA line buffer.
// Primes source line 0 before the playfield, then prefetches line N+1 into the back half
// while half N is shown for 2 or 4 scan lines. Late renders are flagged as underruns.
//   vga_clk, reset     pixel clock, synchronous active-high reset
//   frame_start        frame start pulse, aborts everything
//   prime_start        request line 0 ahead of the playfield
//   pf_start           first playfield scan line, samples vga_scale
//   line_end           last pixel of every scan line
//   vga_scale          0: repeat each source line 2x, 1: 4x
//   rnd                render request channel (master side)
//   display_buffer/base  half being shown and its buffer index
//   active             playfield being displayed
//   underrun           pulse on a swap taken with a render still pending
//   underrun_count     saturating underrun count, cleared only by reset
module line_render_scheduler #(
    parameter int unsigned SRC_LINES   = 240,
    parameter int unsigned LINE_STRIDE = 640
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    prime_start,
    input  logic                    pf_start,
    input  logic                    line_end,
    input  logic                    vga_scale,
    line_render_scheduler_if.master rnd,
    output logic                    display_buffer,
    output logic [10:0]             display_base,
    output logic                    active,
    output logic                    underrun,
    output logic [7:0]              underrun_count
);

    localparam logic [10:0] StrideBase = 11'(LINE_STRIDE);
    localparam logic [10:0] SrcLinesW  = 11'(SRC_LINES);

    typedef enum logic [1:0] {StIdle, StPrime, StArmed, StActive} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [9:0]  line_q, line_d;
    logic        buf_q, buf_d;
    logic [10:0] base_q, base_d;
    logic        abort_q, abort_d;
    logic        issue_q, issue_d;
    logic        disp_q, disp_d;
    logic [10:0] dbase_q, dbase_d;
    logic        active_q, active_d;
    logic        urun_q, urun_d;
    logic [7:0]  ucount_q, ucount_d;
    logic [1:0]  rep_cnt_q, rep_cnt_d;
    logic [1:0]  rep_max_q, rep_max_d;  // latched repeat count minus one
    logic [9:0]  src_q, src_d;

    logic done_ok, swap, last, more;

    assign done_ok = rnd.render_done & req_q;
    assign swap    = (state_q == StActive) & line_end & (rep_cnt_q == rep_max_q);
    // After the swap src_line becomes src_q+1: 'last' ends the frame, 'more' allows a prefetch.
    assign last    = ({1'b0, src_q} + 11'd1) == SrcLinesW;
    assign more    = ({1'b0, src_q} + 11'd2) < SrcLinesW;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            line_q    <= '0;
            buf_q     <= 1'b0;
            base_q    <= '0;
            abort_q   <= 1'b0;
            issue_q   <= 1'b0;
            disp_q    <= 1'b0;
            dbase_q   <= '0;
            active_q  <= 1'b0;
            urun_q    <= 1'b0;
            ucount_q  <= '0;
            rep_cnt_q <= '0;
            rep_max_q <= 2'd1;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            base_q    <= base_d;
            abort_q   <= abort_d;
            issue_q   <= issue_d;
            disp_q    <= disp_d;
            dbase_q   <= dbase_d;
            active_q  <= active_d;
            urun_q    <= urun_d;
            ucount_q  <= ucount_d;
            rep_cnt_q <= rep_cnt_d;
            rep_max_q <= rep_max_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (prime_start) state_d = StPrime;
                StPrime: begin
                    if (pf_start) state_d = StActive;
                    else if (done_ok) state_d = StArmed;
                end
                StArmed:  if (pf_start) state_d = StActive;
                StActive: if (swap && last) state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        req_d     = req_q;
        line_d    = line_q;
        buf_d     = buf_q;
        base_d    = base_q;
        abort_d   = 1'b0;
        issue_d   = 1'b0;
        disp_d    = disp_q;
        dbase_d   = dbase_q;
        active_d  = active_q;
        urun_d    = 1'b0;
        ucount_d  = ucount_q;
        rep_cnt_d = rep_cnt_q;
        rep_max_d = rep_max_q;
        src_d     = src_q;

        if (done_ok) req_d = 1'b0;
        // Request loaded at a swap rises one cycle later so the renderer sees a fresh edge.
        if (issue_q) req_d = 1'b1;

        if (frame_start) begin
            req_d     = 1'b0;
            abort_d   = req_q;
            active_d  = 1'b0;
            rep_cnt_d = '0;
            src_d     = '0;
            disp_d    = 1'b0;
            dbase_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prime_start) begin
                        req_d  = 1'b1;
                        line_d = '0;
                        buf_d  = 1'b0;
                        base_d = '0;
                    end
                end
                StPrime, StArmed: begin
                    if (pf_start) begin
                        active_d  = 1'b1;
                        disp_d    = 1'b0;
                        dbase_d   = '0;
                        rep_cnt_d = '0;
                        src_d     = '0;
                        rep_max_d = vga_scale ? 2'd3 : 2'd1;
                        // A still-pending line 0 request is held; the first swap judges it.
                        if (!req_q || done_ok) begin
                            req_d  = 1'b1;
                            line_d = 10'd1;
                            buf_d  = 1'b1;
                            base_d = StrideBase;
                        end
                    end
                end
                StActive: begin
                    if (line_end) begin
                        if (!swap) begin
                            rep_cnt_d = rep_cnt_q + 2'd1;
                        end else begin
                            rep_cnt_d = '0;
                            disp_d    = ~disp_q;
                            dbase_d   = disp_q ? 11'd0 : StrideBase;
                            src_d     = src_q + 10'd1;
                            req_d     = 1'b0;
                            if (req_q && !rnd.render_done) begin
                                urun_d = 1'b1;
                                if (ucount_q != 8'hFF) ucount_d = ucount_q + 8'd1;
                            end
                            if (last) begin
                                active_d = 1'b0;
                            end else if (more) begin
                                // The half just taken off screen becomes the back half.
                                line_d  = src_q + 10'd2;
                                buf_d   = disp_q;
                                base_d  = disp_q ? StrideBase : 11'd0;
                                issue_d = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rnd.render_req    = req_q;
    assign rnd.render_line   = line_q;
    assign rnd.render_buffer = buf_q;
    assign rnd.render_base   = base_q;
    assign rnd.render_abort  = abort_q;
    assign display_buffer    = disp_q;
    assign display_base      = dbase_q;
    assign active            = active_q;
    assign underrun          = urun_q;
    assign underrun_count    = ucount_q;

endmodule

// File: tb/tb_line_render_scheduler.sv
// Self-checking bench for line_render_scheduler: drives frames of scan lines, plays the
// renderer (on-time, late or coincident completion per source line) and compares against
// expectations derived from line counts: display half = (line_ends / repeat) mod 2.
module tb_line_render_scheduler;
    localparam int Src       = 4;
    localparam int Stride    = 640;
    localparam int L         = 12;
    localparam int CatOnTime = 0;
    localparam int CatLate   = 1;
    localparam int CatCoin   = 2;

    logic        vga_clk = 1'b0;
    logic        reset, frame_start, prime_start, pf_start, line_end, vga_scale;
    logic        display_buffer, active, underrun;
    logic [10:0] display_base;
    logic [7:0]  underrun_count;

    line_render_scheduler_if rif ();

    line_render_scheduler #(
        .SRC_LINES   (Src),
        .LINE_STRIDE (Stride)
    ) dut (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .prime_start    (prime_start),
        .pf_start       (pf_start),
        .line_end       (line_end),
        .vga_scale      (vga_scale),
        .rnd            (rif.master),
        .display_buffer (display_buffer),
        .display_base   (display_base),
        .active         (active),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;
    int exp_ucount = 0;
    int cat_tab[Src];
    int dly_tab[Src];

    // Renderer model state
    logic pend = 1'b0;
    logic req_prev = 1'b0;
    int   cnt = 0;
    int   cur_cat = CatOnTime;
    int   done_kept = 0;
    int   unstable = 0;
    int   obs_line[$];
    int   obs_buf[$];
    int   obs_base[$];

    // One clock: drive inputs, play renderer, record request rises.
    task automatic cycle(input logic fs, input logic ps, input logic pf, input logic le);
        logic d;
        int   ln;
        d = pend && ((cur_cat == CatCoin) ? le : (cur_cat == CatOnTime && cnt == 0));
        frame_start = fs;
        prime_start = ps;
        pf_start = pf;
        line_end = le;
        rif.render_done = d;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        prime_start = 1'b0;
        pf_start = 1'b0;
        line_end = 1'b0;
        rif.render_done = 1'b0;
        if (pend && cnt > 0) cnt--;
        if (d) begin
            pend = 1'b0;
            if (rif.render_req) done_kept++;
        end
        if (!rif.render_req) begin
            pend = 1'b0;
        end else if (!req_prev) begin
            ln = int'(rif.render_line);
            obs_line.push_back(ln);
            obs_buf.push_back(int'(rif.render_buffer));
            obs_base.push_back(int'(rif.render_base));
            pend = 1'b1;
            if (ln < Src) begin
                cur_cat = cat_tab[ln];
                cnt = dly_tab[ln];
            end else begin
                cur_cat = CatLate;
            end
        end else if (obs_line.size() > 0 && int'(rif.render_line) != obs_line[$]) begin
            unstable++;
        end
        req_prev = rif.render_req;
    endtask

    task automatic clear_obs();
        obs_line.delete();
        obs_buf.delete();
        obs_base.delete();
        done_kept = 0;
        unstable = 0;
    endtask

    task automatic set_cats(input int cat2, input int dly);
        for (int i = 0; i < Src; i++) begin
            cat_tab[i] = CatOnTime;
            dly_tab[i] = dly;
        end
        cat_tab[2] = cat2;
    endtask

    task automatic run_frame(input logic scale, input string tag);
        int          rep, s;
        logic        exp_disp, exp_act, exp_urun;
        logic [10:0] exp_base;
        rep = scale ? 4 : 2;
        clear_obs();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        vga_scale = scale;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        vga_scale = ~scale;  // must not matter until the next pf_start
        checks++;
        if (active !== 1'b1 || display_buffer !== 1'b0) begin
            errors++;
            $display("FAIL %s pf_entry: active=%b disp=%b required 1 0", tag, active,
                     display_buffer);
        end
        for (int n = 1; n <= Src * rep; n++) begin
            repeat (L - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            s = n / rep;
            exp_disp = (s % 2) == 1;
            exp_base = exp_disp ? 11'(Stride) : 11'd0;
            exp_act  = n < Src * rep;
            exp_urun = (n % rep == 0) && s < Src && cat_tab[s] == CatLate;
            if (exp_urun && exp_ucount < 255) exp_ucount++;
            checks++;
            if (display_buffer !== exp_disp || display_base !== exp_base || active !== exp_act
                || underrun !== exp_urun || int'(underrun_count) != exp_ucount
                || rif.render_abort !== 1'b0) begin
                errors++;
                $display("FAIL %s line_end %0d: disp=%b base=%0d act=%b urun=%b cnt=%0d abort=%b required %b %0d %b %b %0d 0",
                         tag, n, display_buffer, display_base, active, underrun, underrun_count,
                         rif.render_abort, exp_disp, exp_base, exp_act, exp_urun, exp_ucount);
            end
            if (exp_urun) begin
                checks++;
                if (rif.render_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s drop_at_swap %0d: render_req=%b required 0", tag, n,
                             rif.render_req);
                end
            end
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_line.size() != Src) begin
            errors++;
            $display("FAIL %s req_count: got %0d required %0d", tag, obs_line.size(), Src);
        end else begin
            for (int i = 0; i < Src; i++) begin
                checks++;
                if (obs_line[i] != i || obs_buf[i] != i % 2
                    || obs_base[i] != ((i % 2 == 1) ? Stride : 0)) begin
                    errors++;
                    $display("FAIL %s req%0d: line=%0d buf=%0d base=%0d required %0d %0d %0d",
                             tag, i, obs_line[i], obs_buf[i], obs_base[i], i, i % 2,
                             (i % 2 == 1) ? Stride : 0);
                end
            end
        end
        checks++;
        if (done_kept != 0 || unstable != 0 || active !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: done_ignored=%0d unstable=%0d active=%b required 0 0 0",
                     tag, done_kept, unstable, active);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rif.render_req !== 1'b0 || rif.render_line !== 10'd0 || rif.render_buffer !== 1'b0
            || rif.render_base !== 11'd0 || rif.render_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_render: req=%b line=%0d buf=%b base=%0d abort=%b required all 0",
                     rif.render_req, rif.render_line, rif.render_buffer, rif.render_base,
                     rif.render_abort);
        end
        checks++;
        if (display_buffer !== 1'b0 || display_base !== 11'd0 || active !== 1'b0
            || underrun !== 1'b0 || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_display: disp=%b base=%0d act=%b urun=%b cnt=%0d required all 0",
                     display_buffer, display_base, active, underrun, underrun_count);
        end
        reset = 1'b0;
        exp_ucount = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (active !== 1'b0 || rif.render_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_pf_ignored: act=%b req=%b required 0 0", active, rif.render_req);
        end
    endtask

    task automatic test_normal();
        set_cats(CatOnTime, 10);
        run_frame(1'b0, "normal");
    endtask

    task automatic test_scale1();
        set_cats(CatOnTime, 10);
        run_frame(1'b1, "scale1");
    endtask

    task automatic test_late();
        set_cats(CatLate, 10);
        run_frame(1'b0, "late");
    endtask

    task automatic test_coincident();
        set_cats(CatCoin, 10);
        run_frame(1'b0, "coincident");
    endtask

    task automatic test_random();
        logic sc;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < Src; i++) begin
                cat_tab[i] = (i == 0) ? CatOnTime : int'($urandom_range(0, 2));
                dly_tab[i] = int'($urandom_range(0, 10));
            end
            sc = 1'($urandom_range(0, 1));
            run_frame(sc, "random");
        end
    endtask

    task automatic test_abort();
        set_cats(CatLate, 4);
        clear_obs();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        vga_scale = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            repeat (L - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rif.render_req !== 1'b1 || display_buffer !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: req=%b disp=%b required 1 1", rif.render_req,
                     display_buffer);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rif.render_req !== 1'b0 || rif.render_abort !== 1'b1 || active !== 1'b0
            || display_buffer !== 1'b0 || display_base !== 11'd0) begin
            errors++;
            $display("FAIL abort: req=%b abort=%b act=%b disp=%b base=%0d required 0 1 0 0 0",
                     rif.render_req, rif.render_abort, active, display_buffer, display_base);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rif.render_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_width: abort=%b required 0", rif.render_abort);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (active !== 1'b0 || rif.render_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: act=%b req=%b required 0 0", active, rif.render_req);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rif.render_req !== 1'b1 || rif.render_line !== 10'd0 || rif.render_buffer !== 1'b0) begin
            errors++;
            $display("FAIL abort_reprime: req=%b line=%0d buf=%b required 1 0 0",
                     rif.render_req, rif.render_line, rif.render_buffer);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rif.render_abort !== 1'b1 || rif.render_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_prime: abort=%b req=%b required 1 0", rif.render_abort,
                     rif.render_req);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_cats(CatOnTime, 5);
        cat_tab[1] = CatLate;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        vga_scale = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        vga_scale = 1'b0;
        for (int n = 0; n < 4; n++) begin
            repeat (L - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (exp_ucount < 255) exp_ucount++;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (int'(underrun_count) != exp_ucount || active !== 1'b1 || rif.render_req !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: cnt=%0d act=%b req=%b required %0d 1 1",
                     underrun_count, active, rif.render_req, exp_ucount);
        end
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        exp_ucount = 0;
        checks++;
        if (rif.render_req !== 1'b0 || rif.render_line !== 10'd0 || rif.render_buffer !== 1'b0
            || rif.render_base !== 11'd0 || rif.render_abort !== 1'b0 || display_buffer !== 1'b0
            || display_base !== 11'd0 || active !== 1'b0 || underrun !== 1'b0
            || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset: req=%b line=%0d buf=%b base=%0d abort=%b disp=%b dbase=%0d act=%b urun=%b cnt=%0d required all 0",
                     rif.render_req, rif.render_line, rif.render_buffer, rif.render_base,
                     rif.render_abort, display_buffer, display_base, active, underrun,
                     underrun_count);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (active !== 1'b0 || rif.render_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_needs_prime: act=%b req=%b required 0 0", active,
                     rif.render_req);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rif.render_req !== 1'b1 || rif.render_line !== 10'd0) begin
            errors++;
            $display("FAIL midreset_prime: req=%b line=%0d required 1 0", rif.render_req,
                     rif.render_line);
        end
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        prime_start = 1'b0;
        pf_start = 1'b0;
        line_end = 1'b0;
        vga_scale = 1'b0;
        rif.render_done = 1'b0;
        test_reset();
        test_normal();
        test_scale1();
        test_late();
        test_coincident();
        test_random();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
